// File: rtl/master_spi_if.sv
// Byte-level controller handshake plus the SPI pin bundle for master_spi.
interface master_spi_if;
    logic       start;
    logic       last;
    logic [7:0] data_to_send;
    logic [7:0] data_received;
    logic       busy;
    logic       done;
    logic       cs;
    logic       sck;
    logic       mosi;
    logic       miso;

    modport master (
        input  start, last, data_to_send, miso,
        output data_received, busy, done, cs, sck, mosi
    );

    modport slave (
        output start, last, data_to_send, miso,
        input  data_received, busy, done, cs, sck, mosi
    );
endinterface

// File: rtl/master_spi.sv
// SPI mode-0 master, MSB first, 8-bit frames, with CS held low between bytes
// until the controller marks a byte as the last of the transaction.
module master_spi #(
    parameter int CLOCK_HZ = 25_000_000,
    parameter int SPI_HZ   = 1_000_000
) (
    input logic          clk,
    input logic          rst,
    master_spi_if.master bus
);
    localparam int HALF  = CLOCK_HZ / (2 * SPI_HZ);
    localparam int CNT_W = (HALF < 1) ? 1 : $clog2(HALF + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] TICK_END  = CNT_W'(HALF);

    generate
        if (HALF < 1) begin : g_half_check
            $error("master_spi: CLOCK_HZ must be at least 2*SPI_HZ");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, HOLD, SETUP, HIGH, LOW, END} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_shift, rx_shift, rx_byte;
    logic             last_byte;
    logic             cs_reg, sck_reg, mosi_reg, busy_reg, done_reg;
    logic             accept, finish, enter_high, leave_high;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // END runs one count longer than the other phases so Done lands on its own cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        accept     = 1'b0;
        finish     = 1'b0;
        enter_high = 1'b0;
        leave_high = 1'b0;
        case (state)
            IDLE, HOLD: begin
                cnt_next = '0;
                if (bus.start && !done_reg) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP, LOW: begin
                if (cnt == TICK_LAST) begin
                    cnt_next   = '0;
                    enter_high = 1'b1;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (cnt == TICK_LAST) begin
                    cnt_next   = '0;
                    leave_high = 1'b1;
                    state_next = (bit_cnt == 3'd7) ? END : LOW;
                end
            end
            END: begin
                if (cnt == TICK_END) begin
                    cnt_next   = '0;
                    finish     = 1'b1;
                    state_next = last_byte ? IDLE : HOLD;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_reg   <= 1'b1;
            sck_reg  <= 1'b0;
            mosi_reg <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            rx_byte  <= 8'h00;
            bit_cnt  <= 3'd0;
        end else begin
            done_reg <= finish;
            if (done_reg) busy_reg <= 1'b0;
            if (accept) begin
                cs_reg   <= 1'b0;
                mosi_reg <= bus.data_to_send[7];
                busy_reg <= 1'b1;
                bit_cnt  <= 3'd0;
            end
            if (enter_high) sck_reg <= 1'b1;
            if (leave_high) begin
                sck_reg <= 1'b0;
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt != 3'd7) mosi_reg <= tx_shift[6];
            end
            if (finish) begin
                rx_byte <= rx_shift;
                if (last_byte) begin
                    cs_reg   <= 1'b1;
                    mosi_reg <= 1'b0;
                end
            end
        end
    end

    // MISO is captured on the same edge that raises SCK.
    always_ff @(posedge clk) begin
        if (accept) begin
            tx_shift  <= bus.data_to_send;
            last_byte <= bus.last;
        end else if (leave_high) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
        end
        if (enter_high) rx_shift <= {rx_shift[6:0], bus.miso};
    end

    assign bus.cs            = cs_reg;
    assign bus.sck           = sck_reg;
    assign bus.mosi          = mosi_reg;
    assign bus.busy          = busy_reg;
    assign bus.done          = done_reg;
    assign bus.data_received = rx_byte;
endmodule

// File: tb/tb_master_spi.sv
// Directed bench for master_spi: a HALF=2 instance for protocol scenarios and a default (HALF=12) instance for timing.
module tb_master_spi;
    logic clk = 1'b0;
    logic rst;
    always #20 clk = ~clk;

    master_spi_if bus_f();
    master_spi_if bus_s();

    master_spi #(.CLOCK_HZ(4_000_000), .SPI_HZ(1_000_000)) dut_f (.clk(clk), .rst(rst), .bus(bus_f));
    master_spi dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    int errors = 0;
    int checks = 0;

    int unsigned rise_f = 0, fall_f = 0, ones_f = 0, done_cnt_f = 0, cs_rise_f = 0;
    bit          slave_mode = 1'b0;
    logic [7:0]  slave_val = 8'h00;
    int unsigned fall_base = 0;
    logic [2:0]  slave_idx;

    // Slave shifts a new bit out on every SCK fall after CS drops.
    assign slave_idx  = 3'(7 - (fall_f - fall_base));
    assign bus_f.miso = slave_mode ? slave_val[slave_idx] : bus_f.mosi;
    assign bus_s.miso = bus_s.mosi;

    always @(posedge bus_f.sck) if (!bus_f.cs) begin
        rise_f++;
        if (bus_f.mosi) ones_f++;
    end
    always @(negedge bus_f.sck) fall_f++;
    always @(posedge clk) if (bus_f.done) done_cnt_f++;
    always @(posedge bus_f.cs) cs_rise_f++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fast(input logic [7:0] d, input logic l);
        bus_f.data_to_send = d;
        bus_f.last         = l;
        bus_f.start        = 1'b1;
        tick();
        bus_f.start        = 1'b0;
    endtask

    task automatic wait_done_f(input int limit, output int edges, output bit seen);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < limit) begin
            tick();
            edges++;
            if (bus_f.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus_f.cs !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b want 1", bus_f.cs); end
        checks++; if (bus_f.sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", bus_f.sck); end
        checks++; if (bus_f.mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", bus_f.mosi); end
        checks++; if (bus_f.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_f.busy); end
        checks++; if (bus_f.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus_f.done); end
        checks++; if (bus_f.data_received !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus_f.data_received); end
        checks++; if (bus_s.cs !== 1'b1) begin errors++; $display("FAIL reset_cs_default: got %b want 1", bus_s.cs); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_loopback();
        int unsigned base_r;
        int edges;
        bit seen;
        base_r = rise_f;
        start_fast(8'hA5, 1'b1);
        checks++; if (bus_f.cs !== 1'b0) begin errors++; $display("FAIL lb_cs_low: got %b want 0", bus_f.cs); end
        checks++; if (bus_f.mosi !== 1'b1) begin errors++; $display("FAIL lb_mosi_bit7: got %b want 1", bus_f.mosi); end
        checks++; if (bus_f.busy !== 1'b1) begin errors++; $display("FAIL lb_busy: got %b want 1", bus_f.busy); end
        wait_done_f(60, edges, seen);
        checks++; if (!seen || edges != 35) begin errors++; $display("FAIL lb_latency: got %0d (seen=%b) want 35", edges, seen); end
        checks++; if (bus_f.data_received !== 8'hA5) begin errors++; $display("FAIL lb_data: got %h want a5", bus_f.data_received); end
        checks++; if (bus_f.cs !== 1'b1) begin errors++; $display("FAIL lb_cs_done: got %b want 1", bus_f.cs); end
        checks++; if (bus_f.busy !== 1'b1) begin errors++; $display("FAIL lb_busy_done: got %b want 1", bus_f.busy); end
        checks++; if (rise_f - base_r != 8) begin errors++; $display("FAIL lb_sck_rises: got %0d want 8", rise_f - base_r); end
        tick();
        checks++; if (bus_f.busy !== 1'b0) begin errors++; $display("FAIL lb_busy_after: got %b want 0", bus_f.busy); end
        checks++; if (bus_f.done !== 1'b0) begin errors++; $display("FAIL lb_done_pulse: got %b want 0", bus_f.done); end
    endtask

    task automatic test_two_byte();
        int unsigned base_r, base_cs;
        int edges;
        bit seen;
        tick();
        base_r  = rise_f;
        base_cs = cs_rise_f;
        start_fast(8'h3C, 1'b0);
        wait_done_f(60, edges, seen);
        checks++; if (!seen || edges != 35) begin errors++; $display("FAIL tb1_latency: got %0d (seen=%b) want 35", edges, seen); end
        checks++; if (bus_f.data_received !== 8'h3C) begin errors++; $display("FAIL tb1_data: got %h want 3c", bus_f.data_received); end
        checks++; if (bus_f.cs !== 1'b0) begin errors++; $display("FAIL tb1_cs_done: got %b want 0", bus_f.cs); end
        tick();
        tick();
        checks++; if (bus_f.cs !== 1'b0) begin errors++; $display("FAIL hold_cs: got %b want 0", bus_f.cs); end
        checks++; if (bus_f.sck !== 1'b0) begin errors++; $display("FAIL hold_sck: got %b want 0", bus_f.sck); end
        checks++; if (bus_f.mosi !== 1'b0) begin errors++; $display("FAIL hold_mosi: got %b want 0", bus_f.mosi); end
        checks++; if (bus_f.busy !== 1'b0) begin errors++; $display("FAIL hold_busy: got %b want 0", bus_f.busy); end
        start_fast(8'hC3, 1'b1);
        wait_done_f(60, edges, seen);
        checks++; if (!seen || edges != 35) begin errors++; $display("FAIL tb2_latency: got %0d (seen=%b) want 35", edges, seen); end
        checks++; if (bus_f.data_received !== 8'hC3) begin errors++; $display("FAIL tb2_data: got %h want c3", bus_f.data_received); end
        checks++; if (bus_f.cs !== 1'b1) begin errors++; $display("FAIL tb2_cs_done: got %b want 1", bus_f.cs); end
        checks++; if (rise_f - base_r != 16) begin errors++; $display("FAIL tb_sck_rises: got %0d want 16", rise_f - base_r); end
        checks++; if (cs_rise_f - base_cs != 1) begin errors++; $display("FAIL tb_cs_releases: got %0d want 1", cs_rise_f - base_cs); end
    endtask

    task automatic test_slave_reply();
        int unsigned base_o;
        int edges;
        bit seen;
        tick();
        fall_base  = fall_f;
        slave_val  = 8'h5A;
        slave_mode = 1'b1;
        base_o     = ones_f;
        start_fast(8'hFF, 1'b1);
        wait_done_f(60, edges, seen);
        checks++; if (!seen || edges != 35) begin errors++; $display("FAIL sr_latency: got %0d (seen=%b) want 35", edges, seen); end
        checks++; if (bus_f.data_received !== 8'h5A) begin errors++; $display("FAIL sr_data: got %h want 5a", bus_f.data_received); end
        checks++; if (ones_f - base_o != 8) begin errors++; $display("FAIL sr_mosi_ones: got %0d want 8", ones_f - base_o); end
        slave_mode = 1'b0;
    endtask

    task automatic test_busy_ignore();
        int unsigned base_d;
        int k;
        bit seen;
        tick();
        base_d = done_cnt_f;
        start_fast(8'h96, 1'b1);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            bus_f.data_to_send = 8'h00;
            bus_f.last         = 1'b0;
            bus_f.start        = (k == 4 || k == 19);
            tick();
            bus_f.start = 1'b0;
            k++;
            if (bus_f.done === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen || k != 35) begin errors++; $display("FAIL bi_latency: got %0d (seen=%b) want 35", k, seen); end
        checks++; if (bus_f.data_received !== 8'h96) begin errors++; $display("FAIL bi_data: got %h want 96", bus_f.data_received); end
        checks++; if (bus_f.cs !== 1'b1) begin errors++; $display("FAIL bi_cs_done: got %b want 1", bus_f.cs); end
        repeat (3) tick();
        checks++; if (done_cnt_f - base_d != 1) begin errors++; $display("FAIL bi_done_count: got %0d want 1", done_cnt_f - base_d); end
    endtask

    task automatic test_reset_mid();
        int unsigned base_d;
        int edges;
        bit seen;
        tick();
        base_d = done_cnt_f;
        start_fast(8'h77, 1'b1);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus_f.cs !== 1'b1) begin errors++; $display("FAIL rm_cs: got %b want 1", bus_f.cs); end
        checks++; if (bus_f.sck !== 1'b0) begin errors++; $display("FAIL rm_sck: got %b want 0", bus_f.sck); end
        checks++; if (bus_f.mosi !== 1'b0) begin errors++; $display("FAIL rm_mosi: got %b want 0", bus_f.mosi); end
        checks++; if (bus_f.busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", bus_f.busy); end
        checks++; if (bus_f.data_received !== 8'h00) begin errors++; $display("FAIL rm_data: got %h want 00", bus_f.data_received); end
        repeat (50) tick();
        checks++; if (done_cnt_f != base_d) begin errors++; $display("FAIL rm_no_done: got %0d want 0", done_cnt_f - base_d); end
        start_fast(8'h81, 1'b1);
        wait_done_f(60, edges, seen);
        checks++; if (!seen || edges != 35) begin errors++; $display("FAIL rm_restart_latency: got %0d (seen=%b) want 35", edges, seen); end
        checks++; if (bus_f.data_received !== 8'h81) begin errors++; $display("FAIL rm_restart_data: got %h want 81", bus_f.data_received); end
    endtask

    task automatic test_default_params();
        int k, r1, r2, f1;
        bit seen;
        logic prev;
        tick();
        bus_s.data_to_send = 8'h6B;
        bus_s.last         = 1'b1;
        bus_s.start        = 1'b1;
        tick();
        bus_s.start = 1'b0;
        k = 0; r1 = -1; r2 = -1; f1 = -1; seen = 1'b0;
        prev = bus_s.sck;
        while (!seen && k < 260) begin
            tick();
            k++;
            if (bus_s.sck === 1'b1 && prev === 1'b0) begin
                if (r1 < 0) r1 = k;
                else if (r2 < 0) r2 = k;
            end
            if (bus_s.sck === 1'b0 && prev === 1'b1 && f1 < 0) f1 = k;
            prev = bus_s.sck;
            if (bus_s.done === 1'b1) seen = 1'b1;
        end
        checks++; if (r1 != 12) begin errors++; $display("FAIL dp_first_rise: got %0d want 12", r1); end
        checks++; if (f1 - r1 != 12) begin errors++; $display("FAIL dp_high_phase: got %0d want 12", f1 - r1); end
        checks++; if (r2 - f1 != 12) begin errors++; $display("FAIL dp_low_phase: got %0d want 12", r2 - f1); end
        checks++; if (!seen || k != 205) begin errors++; $display("FAIL dp_latency: got %0d (seen=%b) want 205", k, seen); end
        checks++; if (bus_s.data_received !== 8'h6B) begin errors++; $display("FAIL dp_data: got %h want 6b", bus_s.data_received); end
        checks++; if (bus_s.cs !== 1'b1) begin errors++; $display("FAIL dp_cs_done: got %b want 1", bus_s.cs); end
    endtask

    initial begin
        rst                = 1'b1;
        bus_f.start        = 1'b0;
        bus_f.last         = 1'b0;
        bus_f.data_to_send = 8'h00;
        bus_s.start        = 1'b0;
        bus_s.last         = 1'b0;
        bus_s.data_to_send = 8'h00;
        test_reset();
        test_loopback();
        test_two_byte();
        test_slave_reply();
        test_busy_ignore();
        test_reset_mid();
        test_default_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
